baccarat_datapath: RTL and testbench

Card-and-score datapath feeding the baccarat `state_machine`. It generates a dealt card value every `slowclock` cycle and captures it into one of six hand registers on the controller's `load_*` strobes. It computes registered baccarat hand scores and returns `pscore`, `dscore` and `pcard3` to the controller. The card registers are also exported for the seven-segment display stage.

---
 rtl/baccarat_pkg.sv | 31 +++
 rtl/card_source.sv | 62 ++++++
 rtl/baccarat_datapath.sv | 105 ++++++++++
 tb/tb_baccarat_datapath.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types, constants and scoring helpers for the baccarat card datapath.
// The datapath and the card source both import this package.
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t       CARD_NONE = 4'd0;
    localparam card_t       CARD_ACE  = 4'd1;
    localparam card_t       CARD_KING = 4'd13;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Baccarat point value: 1..9 count at face value.
    // Tens, court cards and an empty slot count as zero.
    function automatic logic [3:0] card_points(input card_t c);
        return (c >= 4'd10) ? 4'd0 : c;
    endfunction

    // Hand score is the three-card point sum modulo 10.
    // The sum is at most 27, so a single conditional subtraction of 20 or 10 is enough.
    function automatic logic [3:0] hand_score(input card_t c1, input card_t c2, input card_t c3);
        logic [4:0] sum;
        sum = {1'b0, card_points(c1)} + {1'b0, card_points(c2)} + {1'b0, card_points(c3)};
        if (sum >= 5'd20) begin
            sum = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/card_source.sv
// Card generator. It offers a new card value (1..13) on every slowclock edge.
//   USE_LFSR=1 : 16-bit right-shifting Galois LFSR; the low nibble is mapped onto 1..13.
//   USE_LFSR=0 : deterministic counter 1, 2, .., 13, 1, ...
// Ports:
//   slowclock - clock
//   resetb    - synchronous active-low reset
//   new_card  - registered card value
module card_source
    import baccarat_pkg::*;
#(
    parameter bit          USE_LFSR  = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       slowclock,
    input  logic       resetb,
    output logic [3:0] new_card
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    if (USE_LFSR) begin : g_lfsr
        logic [15:0] lfsr_q, lfsr_d;
        logic [3:0]  nib;

        always_comb begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end

        always_ff @(posedge slowclock) begin
            if (!resetb) begin
                lfsr_q <= SeedEff;
            end else begin
                lfsr_q <= lfsr_d;
            end
        end

        // The 16 nibble values fold onto 13 cards.
        // 0..12 map to 1..13; 13..15 wrap to 1..3.
        assign nib = lfsr_q[3:0];
        always_comb begin
            new_card = (nib <= 4'd12) ? nib + 4'd1 : nib - 4'd12;
        end
    end else begin : g_count
        card_t count_q, count_d;

        always_comb begin
            count_d = (count_q == CARD_KING) ? CARD_ACE : count_q + 4'd1;
        end

        always_ff @(posedge slowclock) begin
            if (!resetb) begin
                count_q <= CARD_ACE;
            end else begin
                count_q <= count_d;
            end
        end

        assign new_card = count_q;
    end

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card-and-score datapath. It captures the offered card into the six hand
// registers on the controller's load strobes. It returns registered hand scores and
// exports the cards for display.
// Ports:
//   slowclock, resetb         - clock, synchronous active-low reset
//   load_{p,d}card{1,2,3}     - capture strobes (any combination allowed)
//   new_card                  - card currently offered
//   {p,d}card{1,2,3}          - hand registers, 0 = empty
//   pscore, dscore            - hand scores 0..9, one cycle behind the card registers
//   load_err                  - sticky: two or more loads seen in one cycle
module baccarat_datapath
    import baccarat_pkg::*;
#(
    parameter bit          USE_LFSR  = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       slowclock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] new_card,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       load_err
);

    card_source #(
        .USE_LFSR  (USE_LFSR),
        .LFSR_SEED (LFSR_SEED)
    ) u_card_source (
        .slowclock (slowclock),
        .resetb    (resetb),
        .new_card  (new_card)
    );

    logic [2:0] pload, dload;
    logic [5:0] load_vec;
    logic       multi_load;

    card_t      pcard_q [3];
    card_t      pcard_d [3];
    card_t      dcard_q [3];
    card_t      dcard_d [3];
    logic [3:0] pscore_q, pscore_d;
    logic [3:0] dscore_q, dscore_d;
    logic       load_err_q, load_err_d;

    assign pload    = {load_pcard3, load_pcard2, load_pcard1};
    assign dload    = {load_dcard3, load_dcard2, load_dcard1};
    assign load_vec = {dload, pload};
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_load = (load_vec & (load_vec - 6'd1)) != 6'd0;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pcard_d[i] = pload[i] ? new_card : pcard_q[i];
            dcard_d[i] = dload[i] ? new_card : dcard_q[i];
        end
        // Scores come from the registers, so they trail a load by one extra cycle.
        pscore_d   = hand_score(pcard_q[0], pcard_q[1], pcard_q[2]);
        dscore_d   = hand_score(dcard_q[0], dcard_q[1], dcard_q[2]);
        load_err_d = load_err_q | multi_load;
    end

    always_ff @(posedge slowclock) begin
        if (!resetb) begin
            for (int i = 0; i < 3; i++) begin
                pcard_q[i] <= CARD_NONE;
                dcard_q[i] <= CARD_NONE;
            end
            pscore_q   <= 4'd0;
            dscore_q   <= 4'd0;
            load_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pcard_q[i] <= pcard_d[i];
                dcard_q[i] <= dcard_d[i];
            end
            pscore_q   <= pscore_d;
            dscore_q   <= dscore_d;
            load_err_q <= load_err_d;
        end
    end

    assign pcard1   = pcard_q[0];
    assign pcard2   = pcard_q[1];
    assign pcard3   = pcard_q[2];
    assign dcard1   = dcard_q[0];
    assign dcard2   = dcard_q[1];
    assign dcard3   = dcard_q[2];
    assign pscore   = pscore_q;
    assign dscore   = dscore_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_baccarat_datapath.sv
// Bench for baccarat_datapath: one counter-mode and one LFSR-mode instance share the
// same stimulus. Expected card and score values are queued when a load is driven. They
// are popped and compared once the registers should show them.
module tb_baccarat_datapath;

    logic       slowclock;
    logic       resetb;
    logic [5:0] loads;  // bits 0..2 pcard1..3, bits 3..5 dcard1..3

    logic [3:0] new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
    logic       load_err;
    logic [3:0] l_new_card, l_pcard1, l_pcard2, l_pcard3, l_dcard1, l_dcard2, l_dcard3;
    logic [3:0] l_pscore, l_dscore;
    logic       l_load_err;

    int errors = 0;
    int checks = 0;

    // Reference models of the two card sources
    logic [3:0]  m_cnt;
    logic [15:0] m_lfsr;

    typedef struct {
        int         id;
        logic [3:0] exp;
    } exp_t;
    exp_t sb_q[$];

    baccarat_datapath #(.USE_LFSR(1'b0), .LFSR_SEED(16'hACE1)) dut_c (
        .slowclock   (slowclock),
        .resetb      (resetb),
        .load_pcard1 (loads[0]),
        .load_pcard2 (loads[1]),
        .load_pcard3 (loads[2]),
        .load_dcard1 (loads[3]),
        .load_dcard2 (loads[4]),
        .load_dcard3 (loads[5]),
        .new_card    (new_card),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .load_err    (load_err)
    );

    baccarat_datapath #(.USE_LFSR(1'b1), .LFSR_SEED(16'hACE1)) dut_l (
        .slowclock   (slowclock),
        .resetb      (resetb),
        .load_pcard1 (loads[0]),
        .load_pcard2 (loads[1]),
        .load_pcard3 (loads[2]),
        .load_dcard1 (loads[3]),
        .load_dcard2 (loads[4]),
        .load_dcard3 (loads[5]),
        .new_card    (l_new_card),
        .pcard1      (l_pcard1),
        .pcard2      (l_pcard2),
        .pcard3      (l_pcard3),
        .dcard1      (l_dcard1),
        .dcard2      (l_dcard2),
        .dcard3      (l_dcard3),
        .pscore      (l_pscore),
        .dscore      (l_dscore),
        .load_err    (l_load_err)
    );

    initial begin
        slowclock = 1'b0;
        forever #5 slowclock = ~slowclock;
    end

    function automatic logic [3:0] lfsr_card(input logic [15:0] s);
        logic [3:0] v;
        v = s[3:0];
        return (v <= 4'd12) ? v + 4'd1 : v - 4'd12;
    endfunction

    function automatic logic [3:0] sig_val(input int id);
        case (id)
            0:       return pcard1;
            1:       return pcard2;
            2:       return pcard3;
            3:       return dcard1;
            4:       return dcard2;
            5:       return dcard3;
            6:       return pscore;
            7:       return dscore;
            default: return 4'hx;
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            0:       return "pcard1";
            1:       return "pcard2";
            2:       return "pcard3";
            3:       return "dcard1";
            4:       return "dcard2";
            5:       return "dcard3";
            6:       return "pscore";
            7:       return "dscore";
            default: return "unknown";
        endcase
    endfunction

    // One clock edge; models advance with it. Outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge slowclock);
        if (!resetb) begin
            m_cnt  = 4'd1;
            m_lfsr = 16'hACE1;
        end else begin
            m_cnt  = (m_cnt == 4'd13) ? 4'd1 : m_cnt + 4'd1;
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        #1;
    endtask

    task automatic advance_to(input logic [3:0] v);
        for (int n = 0; n < 14 && m_cnt != v; n++) tick();
    endtask

    // Drive one cycle of loads and queue the card each register should capture.
    task automatic do_load(input logic [5:0] mask);
        loads = mask;
        for (int i = 0; i < 6; i++) begin
            if (mask[i]) sb_q.push_back('{id: i, exp: m_cnt});
        end
        tick();
        loads = '0;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            loads = 6'($urandom);
            tick();
        end
        loads = '0;
        for (int id = 0; id < 8; id++) begin
            checks++;
            if (sig_val(id) !== 4'd0) begin
                errors++;
                $display("FAIL reset_%s: got %0d expected 0", sig_name(id), sig_val(id));
            end
        end
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_err: got %0b expected 0", load_err);
        end
        checks++;
        if (new_card !== 4'd1) begin
            errors++;
            $display("FAIL reset_new_card: got %0d expected 1", new_card);
        end
        resetb = 1'b1;
    endtask

    task automatic test_counter_hand();
        exp_t e;
        checks++;
        if (new_card !== 4'd1) begin
            errors++;
            $display("FAIL first_card: got %0d expected 1", new_card);
        end
        do_load(6'b000001);
        advance_to(4'd3);
        do_load(6'b001000);
        advance_to(4'd9);
        do_load(6'b000010);
        advance_to(4'd13);
        do_load(6'b010000);
        sb_q.push_back('{id: 6, exp: 4'd0});
        sb_q.push_back('{id: 7, exp: 4'd3});
        tick();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (sig_val(e.id) !== e.exp) begin
                errors++;
                $display("FAIL hand_%s: got %0d expected %0d", sig_name(e.id), sig_val(e.id), e.exp);
            end
        end
    endtask

    task automatic test_wrap_face();
        exp_t e;
        advance_to(4'd1);
        for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if (new_card !== m_cnt) begin
                errors++;
                $display("FAIL wrap_step: got %0d expected %0d", new_card, m_cnt);
            end
        end
        checks++;
        if (new_card !== 4'd1) begin
            errors++;
            $display("FAIL wrap_return: got %0d expected 1", new_card);
        end
        advance_to(4'd10);
        do_load(6'b001000);
        do_load(6'b010000);
        do_load(6'b100000);
        // Player hand must be untouched by the dealer loads.
        sb_q.push_back('{id: 0, exp: 4'd1});
        sb_q.push_back('{id: 1, exp: 4'd9});
        tick();
        sb_q.push_back('{id: 7, exp: 4'd0});
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (sig_val(e.id) !== e.exp) begin
                errors++;
                $display("FAIL face_%s: got %0d expected %0d", sig_name(e.id), sig_val(e.id), e.exp);
            end
        end
    endtask

    task automatic test_max_sum();
        exp_t e;
        advance_to(4'd9);
        do_load(6'b000001);
        advance_to(4'd9);
        do_load(6'b000010);
        advance_to(4'd9);
        checks++;
        if (pcard3 !== 4'd0) begin
            errors++;
            $display("FAIL pcard3_empty: got %0d expected 0", pcard3);
        end
        do_load(6'b000100);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (sig_val(e.id) !== e.exp) begin
                errors++;
                $display("FAIL max_%s: got %0d expected %0d", sig_name(e.id), sig_val(e.id), e.exp);
            end
        end
        sb_q.push_back('{id: 6, exp: 4'd7});
        tick();
        e = sb_q.pop_front();
        checks++;
        if (sig_val(e.id) !== e.exp) begin
            errors++;
            $display("FAIL max_pscore: got %0d expected %0d", sig_val(e.id), e.exp);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL err_before: got %0b expected 0", load_err);
        end
        advance_to(4'd5);
        do_load(6'b001001);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (sig_val(e.id) !== e.exp) begin
                errors++;
                $display("FAIL simul_%s: got %0d expected %0d", sig_name(e.id), sig_val(e.id), e.exp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (load_err !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky: got %0b expected 1", load_err);
            end
            tick();
        end
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        checks++;
        if (load_err !== 1'b0 || pcard1 !== 4'd0 || dcard1 !== 4'd0) begin
            errors++;
            $display("FAIL err_reset: got err=%0b p1=%0d d1=%0d expected 0 0 0",
                     load_err, pcard1, dcard1);
        end
    endtask

    task automatic test_lfsr();
        logic [3:0] first_seq [16];
        logic [3:0] exp_d1;
        checks++;
        if (l_new_card !== 4'd2) begin
            errors++;
            $display("FAIL lfsr_first: got %0d expected 2", l_new_card);
        end
        for (int i = 0; i < 16; i++) begin
            first_seq[i] = lfsr_card(m_lfsr);
            checks++;
            if (l_new_card !== first_seq[i]) begin
                errors++;
                $display("FAIL lfsr_seq: got %0d expected %0d", l_new_card, first_seq[i]);
            end
            if (i == 3) loads = 6'b000001;
            tick();
            loads = '0;
            if (i == 3) begin
                checks++;
                if (l_pcard1 !== first_seq[3]) begin
                    errors++;
                    $display("FAIL lfsr_load: got %0d expected %0d", l_pcard1, first_seq[3]);
                end
            end
        end
        for (int i = 0; i < 1000; i++) begin
            tick();
            checks++;
            if (!(l_new_card inside {[4'd1:4'd13]})) begin
                errors++;
                $display("FAIL lfsr_range: got %0d expected 1..13", l_new_card);
            end
            checks++;
            if (l_new_card !== lfsr_card(m_lfsr)) begin
                errors++;
                $display("FAIL lfsr_model: got %0d expected %0d", l_new_card, lfsr_card(m_lfsr));
            end
        end
        exp_d1 = lfsr_card(m_lfsr);
        loads = 6'b001000;
        tick();
        loads = '0;
        checks++;
        if (l_dcard1 !== exp_d1) begin
            errors++;
            $display("FAIL lfsr_dcard1: got %0d expected %0d", l_dcard1, exp_d1);
        end
        resetb = 1'b0;
        loads = 6'b111111;
        tick();
        loads = '0;
        resetb = 1'b1;
        checks++;
        if (l_pcard1 !== 4'd0 || l_dcard1 !== 4'd0 || l_load_err !== 1'b0) begin
            errors++;
            $display("FAIL lfsr_reset: got p1=%0d d1=%0d err=%0b expected 0 0 0",
                     l_pcard1, l_dcard1, l_load_err);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (l_new_card !== first_seq[i]) begin
                errors++;
                $display("FAIL lfsr_replay: got %0d expected %0d", l_new_card, first_seq[i]);
            end
            tick();
        end
    endtask

    initial begin
        resetb = 1'b0;
        loads  = '0;
        test_reset();
        test_counter_hand();
        test_wrap_face();
        test_max_sum();
        test_simultaneous();
        test_lfsr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
